// File: rtl/tb_sim_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sim_ctrl_pkg
//  Purpose  : Shared definitions for the simulation-control peripheral:
//             register word offsets, CTRL bit positions, register-select
//             enum and small decode/merge helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package tb_sim_ctrl_pkg;

  // Word offsets (byte address bits [4:2]) inside the peripheral window
  localparam logic [2:0] OFF_PRINT  = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_EXIT   = 3'd2;
  localparam logic [2:0] OFF_TCMP   = 3'd3;
  localparam logic [2:0] OFF_TCNT   = 3'd4;
  localparam logic [2:0] OFF_CTRL   = 3'd5;
  localparam logic [2:0] OFF_LEVEL  = 3'd6;

  // CTRL register bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_PEND_BIT = 1;

  typedef enum logic [2:0] {
    SEL_PRINT  = 3'd0,
    SEL_STATUS = 3'd1,
    SEL_EXIT   = 3'd2,
    SEL_TCMP   = 3'd3,
    SEL_TCNT   = 3'd4,
    SEL_CTRL   = 3'd5,
    SEL_LEVEL  = 3'd6,
    SEL_NONE   = 3'd7
  } reg_sel_e;

  // Map a word offset onto a register select; anything unknown is SEL_NONE
  function automatic reg_sel_e decode_sel(input logic [2:0] off);
    reg_sel_e sel;
    case (off)
      OFF_PRINT:  sel = SEL_PRINT;
      OFF_STATUS: sel = SEL_STATUS;
      OFF_EXIT:   sel = SEL_EXIT;
      OFF_TCMP:   sel = SEL_TCMP;
      OFF_TCNT:   sel = SEL_TCNT;
      OFF_CTRL:   sel = SEL_CTRL;
      OFF_LEVEL:  sel = SEL_LEVEL;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  // Replace only the byte lanes selected by be
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tb_sim_ctrl_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sim_ctrl_fifo
//  Purpose  : Synchronous FIFO for stdout characters. Push while full and
//             pop while empty are ignored. Reset discards contents by
//             clearing pointers and level; storage itself is not reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sim_ctrl_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage write; contents are don't-care until covered by the level count
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tb_sim_ctrl_periph.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sim_ctrl_periph
//  Purpose  : OBI-attached simulation-control peripheral: pass/fail/exit
//             indications, buffered stdout characters and a timer interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sim_ctrl_periph
  import tb_sim_ctrl_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] PASS_MAGIC = 32'd123456789,
  parameter logic [31:0] FAIL_MAGIC = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        char_valid_o,
  output logic [7:0]  char_o,
  input  logic        char_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o,
  output logic        irq_timer_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  reg_sel_e    w_sel;
  logic        w_print_wr_req;
  logic        w_fire;
  logic        w_wr;
  logic        w_rd;
  logic        w_push;
  logic        w_pop;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [7:0]  w_fifo_head;
  logic [AW:0] w_fifo_level;
  logic        w_cnt_wr;
  logic        w_ctrl_wr;
  logic        w_match;
  logic        w_pend_clr;
  logic        w_unused_addr;

  logic        rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic        passed_q, failed_q, exit_valid_q;
  logic [31:0] exit_value_q;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] cnt_q, cnt_d;
  logic        en_q, en_d;
  logic        pend_q, pend_d;

  // Only the word offset is decoded; the rest of the address is ignored
  assign w_unused_addr = ^{addr_i[31:5], addr_i[1:0]};
  assign w_sel         = decode_sel(addr_i[4:2]);

  // A PRINT write into a full FIFO waits; a same-cycle pop does not help
  assign w_print_wr_req = req_i & we_i & (w_sel == SEL_PRINT);
  assign gnt_o          = req_i & ~(w_print_wr_req & w_fifo_full);
  assign w_fire         = req_i & gnt_o;
  assign w_wr           = w_fire & we_i;
  assign w_rd           = w_fire & ~we_i;

  assign w_push = w_wr & (w_sel == SEL_PRINT);
  assign w_pop  = ~w_fifo_empty & char_ready_i;

  tb_sim_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .data_i  (wdata_i[7:0]),
    .pop_i   (w_pop),
    .data_o  (w_fifo_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .level_o (w_fifo_level)
  );

  // Head byte is masked when empty so stale storage never leaks out
  assign char_valid_o = ~w_fifo_empty;
  assign char_o       = w_fifo_empty ? 8'h00 : w_fifo_head;

  // Read data mux; writes and unmapped offsets return zero
  always_comb begin
    rdata_d = '0;
    if (w_rd) begin
      case (w_sel)
        SEL_TCMP:  rdata_d = cmp_q;
        SEL_TCNT:  rdata_d = cnt_q;
        SEL_CTRL: begin
          rdata_d[CTRL_EN_BIT]   = en_q;
          rdata_d[CTRL_PEND_BIT] = pend_q;
        end
        SEL_LEVEL: rdata_d = 32'(w_fifo_level);
        default:   rdata_d = '0;
      endcase
    end
  end

  // Timer control: CTRL bits live in byte lane 0 only
  assign w_cnt_wr   = w_wr & (w_sel == SEL_TCNT);
  assign w_ctrl_wr  = w_wr & (w_sel == SEL_CTRL) & be_i[0];
  assign w_pend_clr = w_ctrl_wr & wdata_i[CTRL_PEND_BIT];
  // A counter write in the same cycle masks the compare match
  assign w_match    = en_q & (cmp_q != '0) & (cnt_q == cmp_q) & ~w_cnt_wr;

  // Timer next-state: count write beats match beats increment; set beats clear
  always_comb begin
    cmp_d  = cmp_q;
    cnt_d  = cnt_q;
    en_d   = en_q;
    pend_d = pend_q;
    if (w_wr && (w_sel == SEL_TCMP)) cmp_d = be_merge(cmp_q, wdata_i, be_i);
    if (w_ctrl_wr) en_d = wdata_i[CTRL_EN_BIT];
    if (w_cnt_wr)      cnt_d = be_merge(cnt_q, wdata_i, be_i);
    else if (w_match)  cnt_d = '0;
    else if (en_q)     cnt_d = cnt_q + 32'd1;
    if (w_match)         pend_d = 1'b1;
    else if (w_pend_clr) pend_d = 1'b0;
  end

  // Bus response: one-cycle rvalid with registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= w_fire;
      rdata_q  <= rdata_d;
    end
  end

  // Pass/fail/exit indications, pulsed the cycle after grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_value_q <= '0;
    end else begin
      passed_q     <= w_wr & (w_sel == SEL_STATUS) & (wdata_i == PASS_MAGIC);
      failed_q     <= w_wr & (w_sel == SEL_STATUS) & (wdata_i == FAIL_MAGIC);
      exit_valid_q <= w_wr & (w_sel == SEL_EXIT);
      if (w_wr && (w_sel == SEL_EXIT)) exit_value_q <= wdata_i;
    end
  end

  // Timer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q  <= '0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cmp_q  <= cmp_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      pend_q <= pend_d;
    end
  end

  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = exit_valid_q;
  assign exit_value_o   = exit_value_q;
  assign irq_timer_o    = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_tb_sim_ctrl_periph.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tb_sim_ctrl_periph
//  Purpose  : Directed self-checking bench for tb_sim_ctrl_periph.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tb_sim_ctrl_periph;

  localparam logic [31:0] A_PRINT  = 32'h00;
  localparam logic [31:0] A_STATUS = 32'h04;
  localparam logic [31:0] A_EXIT   = 32'h08;
  localparam logic [31:0] A_TCMP   = 32'h0C;
  localparam logic [31:0] A_TCNT   = 32'h10;
  localparam logic [31:0] A_CTRL   = 32'h14;
  localparam logic [31:0] A_LEVEL  = 32'h18;
  localparam logic [31:0] A_UNMAP  = 32'h1C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        char_valid_o;
  logic [7:0]  char_o;
  logic        char_ready_i = 1'b0;
  logic        tests_passed_o;
  logic        tests_failed_o;
  logic        exit_valid_o;
  logic [31:0] exit_value_o;
  logic        irq_timer_o;

  int vectors = 0;
  int miscompares = 0;

  tb_sim_ctrl_periph #(
    .FIFO_DEPTH (16),
    .PASS_MAGIC (32'd123456789),
    .FAIL_MAGIC (32'd1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .gnt_o          (gnt_o),
    .addr_i         (addr_i),
    .we_i           (we_i),
    .be_i           (be_i),
    .wdata_i        (wdata_i),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .char_valid_o   (char_valid_o),
    .char_o         (char_o),
    .char_ready_i   (char_ready_i),
    .tests_passed_o (tests_passed_o),
    .tests_failed_o (tests_failed_o),
    .exit_valid_o   (exit_valid_o),
    .exit_value_o   (exit_value_o),
    .irq_timer_o    (irq_timer_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Entered 1ns after a rising edge; returns 1ns after the granting edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; be_i = be;
    #1;
    n = 0;
    while (gnt_o !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check("wr_gnt", {31'b0, gnt_o}, 32'd1);
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0; wdata_i = '0; be_i = '0;
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
    int n;
    req_i = 1'b1; we_i = 1'b0; addr_i = a; be_i = 4'hF;
    #1;
    n = 0;
    while (gnt_o !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check("rd_gnt", {31'b0, gnt_o}, 32'd1);
    @(posedge clk); #1;
    req_i = 1'b0; be_i = '0;
    check("rd_rvalid", {31'b0, rvalid_o}, 32'd1);
    check(tag, rdata_o, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_flags", {25'b0, gnt_o, rvalid_o, char_valid_o, tests_passed_o,
                        tests_failed_o, exit_valid_o, irq_timer_o}, 32'd0);
    check("rst_char", {24'b0, char_o}, 32'd0);
    check("rst_exitval", exit_value_o, 32'd0);
    rd_chk(A_TCMP,  32'd0, "rst_tcmp");
    rd_chk(A_TCNT,  32'd0, "rst_tcnt");
    rd_chk(A_CTRL,  32'd0, "rst_ctrl");
    rd_chk(A_LEVEL, 32'd0, "rst_level");

    // ---------------- stdout with sink ready ----------------
    char_ready_i = 1'b1;
    wr(A_PRINT, 32'h0000_0041, 4'hF);
    check("char_A", {24'b0, char_o}, 32'h41);
    wr(A_PRINT, 32'hFFFF_FF42, 4'h0);
    check("char_B", {24'b0, char_o}, 32'h42);
    wr(A_PRINT, 32'h0000_000A, 4'hF);
    check("char_nl", {24'b0, char_o}, 32'h0A);
    @(posedge clk); #1;
    check("drained_valid", {31'b0, char_valid_o}, 32'd0);
    rd_chk(A_LEVEL, 32'd0, "level_drained");

    // ---------------- unmapped offset ----------------
    wr(A_UNMAP, 32'hFFFF_FFFF, 4'hF);
    rd_chk(A_UNMAP, 32'd0, "unmapped_rd");

    // ---------------- STATUS ----------------
    wr(A_STATUS, 32'd123456789, 4'hF);
    check("pass_pulse", {30'b0, tests_passed_o, tests_failed_o}, 32'b10);
    @(posedge clk); #1;
    check("pass_one_cycle", {31'b0, tests_passed_o}, 32'd0);
    wr(A_STATUS, 32'd1, 4'hF);
    check("fail_pulse", {30'b0, tests_passed_o, tests_failed_o}, 32'b01);
    wr(A_STATUS, 32'd7, 4'hF);
    check("status_other", {30'b0, tests_passed_o, tests_failed_o}, 32'b00);

    // ---------------- EXIT ----------------
    wr(A_EXIT, 32'd5, 4'hF);
    check("exit_pulse", {31'b0, exit_valid_o}, 32'd1);
    check("exit_val5", exit_value_o, 32'd5);
    @(posedge clk); #1;
    check("exit_pulse_end", {31'b0, exit_valid_o}, 32'd0);
    check("exit_val_held", exit_value_o, 32'd5);
    wr(A_EXIT, 32'd0, 4'hF);
    check("exit_val0", exit_value_o, 32'd0);
    check("exit_pulse2", {31'b0, exit_valid_o}, 32'd1);
    wr(A_EXIT, 32'hDEAD_BEEF, 4'h0);
    check("exit_ignores_be", exit_value_o, 32'hDEAD_BEEF);

    // ---------------- timer ----------------
    wr(A_TCMP, 32'hAABB_CCDD, 4'b0101);
    rd_chk(A_TCMP, 32'h00BB_00DD, "tcmp_be");
    wr(A_TCMP, 32'd3, 4'hF);
    check("wr_rvalid", {31'b0, rvalid_o}, 32'd1);
    check("wr_rdata_zero", rdata_o, 32'd0);
    wr(A_CTRL, 32'd1, 4'hF);
    check("irq_at_enable", {31'b0, irq_timer_o}, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("irq_early", {31'b0, irq_timer_o}, 32'd0);
    @(posedge clk); #1;
    check("irq_rise", {31'b0, irq_timer_o}, 32'd1);
    rd_chk(A_TCNT, 32'd0, "cnt_restart");
    repeat (2) begin @(posedge clk); #1; end
    wr(A_CTRL, 32'd3, 4'hF);
    check("set_wins", {31'b0, irq_timer_o}, 32'd1);
    wr(A_CTRL, 32'd3, 4'hF);
    check("pend_clear", {31'b0, irq_timer_o}, 32'd0);
    rd_chk(A_CTRL, 32'd1, "ctrl_rd");

    // ---------------- FIFO full / backpressure ----------------
    char_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) wr(A_PRINT, 32'(32'h61 + i), 4'hF);
    req_i = 1'b1; we_i = 1'b1; addr_i = A_PRINT; wdata_i = 32'h71; be_i = 4'hF;
    #1;
    check("gnt_full", {31'b0, gnt_o}, 32'd0);
    @(posedge clk); #1;
    check("gnt_full_hold", {31'b0, gnt_o}, 32'd0);
    char_ready_i = 1'b1;
    #1;
    check("gnt_no_bypass", {31'b0, gnt_o}, 32'd0);
    @(posedge clk); #1;
    char_ready_i = 1'b0;
    check("gnt_after_pop", {31'b0, gnt_o}, 32'd1);
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0; wdata_i = '0; be_i = '0;
    check("head_after_pop", {24'b0, char_o}, 32'h62);
    rd_chk(A_LEVEL, 32'd16, "level_full");

    // Drain 11 of 16, leaving 5 entries
    char_ready_i = 1'b1;
    repeat (11) @(posedge clk);
    #1 char_ready_i = 1'b0;
    check("head_after_drain", {24'b0, char_o}, 32'h6D);
    rd_chk(A_LEVEL, 32'd5, "level_five");

    // ---------------- reset with a read in flight ----------------
    req_i = 1'b1; we_i = 1'b0; addr_i = A_LEVEL; be_i = 4'hF;
    #1;
    @(posedge clk);
    rst_n = 1'b0;
    req_i = 1'b0; be_i = '0;
    #1;
    check("rst_mid_flags", {25'b0, gnt_o, rvalid_o, char_valid_o, tests_passed_o,
                            tests_failed_o, exit_valid_o, irq_timer_o}, 32'd0);
    check("rst_mid_char", {24'b0, char_o}, 32'd0);
    check("rst_mid_exitval", exit_value_o, 32'd0);
    check("rst_mid_rdata", rdata_o, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rvalid", {31'b0, rvalid_o}, 32'd0);
    rd_chk(A_LEVEL, 32'd0, "level_after_rst");
    check("post_rst_valid", {31'b0, char_valid_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
